// File: rtl/vram_fetch_pkg.sv
// Shared widths, FSM state type and the pixel address helper for the VRAM line fetcher.
package vram_fetch_pkg;

  localparam int VRAM_ADDR_W = 18;
  localparam int LINE_Y_W    = 11;
  localparam int PIX_X_W     = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Byte address of a pixel; the product is formed wide, then wraps modulo 2^VRAM_ADDR_W.
  function automatic logic [VRAM_ADDR_W-1:0] pixel_addr(
    input logic [LINE_Y_W-1:0] line_y,
    input logic [PIX_X_W-1:0]  pix_x,
    input int unsigned         pitch
  );
    logic [31:0] full_addr;
    full_addr = 32'(line_y) * 32'(pitch) + 32'(pix_x) * 32'd2;
    return full_addr[VRAM_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/vram_line_fifo.sv
// Synchronous FIFO with flush; power-of-two depth, pops of an empty FIFO are ignored.
module vram_line_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers and count define validity, and empty forces the head to 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/vram_line_fetch.sv
// Fetches one display line of 16-bit pixels from VRAM into a small pixel FIFO.
// Optional VRAM_LINE_FETCH_DOUBLE_SCAN_EN fetches every VRAM line twice.
module vram_line_fetch
  import vram_fetch_pkg::*;
#(
  parameter int PIXELS_PER_LINE = 360,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_of_frame,
  input  logic                   start_of_line,
  output logic                   mem_rd_req,
  output logic [VRAM_ADDR_W-1:0] mem_addr,
  input  logic                   mem_ack,
  input  logic [15:0]            mem_rd_data,
  output logic                   pix_valid,
  output logic [15:0]            pix_data,
  input  logic                   pix_ready,
  output logic                   fetch_busy
);

  localparam int unsigned         PITCH  = PIXELS_PER_LINE * 2;
  localparam logic [PIX_X_W-1:0]  LAST_X = PIX_X_W'(PIXELS_PER_LINE - 1);
  localparam int                  CNT_W  = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e             state_q, state_d;
  logic [LINE_Y_W-1:0]      line_y_q, line_y_d;
  logic [PIX_X_W-1:0]       pix_x_q, pix_x_d;
  logic                     req_q, req_d;
  logic [VRAM_ADDR_W-1:0]   addr_q, addr_d;
  logic                     discard_q, discard_d;
  logic                     restart_q, restart_d;
`ifdef VRAM_LINE_FETCH_DOUBLE_SCAN_EN
  logic                     parity_q, parity_d;
`endif

  logic                     ack;
  logic                     line_adv;
  logic                     try_issue;
  logic                     fifo_room;
  logic                     fifo_push;
  logic                     fifo_flush;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CNT_W-1:0]         fifo_count;

  assign ack = req_q && mem_ack;

  // Entries already queued plus the one in flight must leave room for the next word.
  assign fifo_room = fifo_flush ||
                     (!fifo_full && (32'(fifo_count) + 32'(req_q)) < 32'(FIFO_DEPTH));

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    line_y_d   = line_y_q;
    pix_x_d    = pix_x_q;
    req_d      = req_q;
    addr_d     = addr_q;
    discard_d  = discard_q;
    restart_d  = restart_q;
`ifdef VRAM_LINE_FETCH_DOUBLE_SCAN_EN
    parity_d   = parity_q;
`endif
    line_adv   = 1'b0;
    try_issue  = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;

    if (start_of_frame) begin
      fifo_flush = 1'b1;
      line_y_d   = '0;
      pix_x_d    = '0;
      discard_d  = 1'b0;
`ifdef VRAM_LINE_FETCH_DOUBLE_SCAN_EN
      parity_d   = 1'b0;
`endif
      if (req_q && !mem_ack) begin
        // The in-flight request cannot be withdrawn; wait out its ack in DRAIN.
        state_d   = DRAIN;
        restart_d = start_of_line;
      end else begin
        req_d     = 1'b0;
        restart_d = 1'b0;
        state_d   = start_of_line ? FETCH : IDLE;
        try_issue = start_of_line;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_of_line) begin
            state_d   = FETCH;
            pix_x_d   = '0;
            try_issue = 1'b1;
          end
        end
        FETCH: begin
          if (start_of_line) begin
            fifo_flush = 1'b1;
            pix_x_d    = '0;
            line_adv   = 1'b1;
            if (req_q && !mem_ack) begin
              discard_d = 1'b1;
            end else if (req_q) begin
              req_d     = 1'b0;
              discard_d = 1'b0;
            end else begin
              try_issue = 1'b1;
            end
          end else if (ack) begin
            req_d = 1'b0;
            if (discard_q) begin
              discard_d = 1'b0;
            end else begin
              fifo_push = 1'b1;
              if (pix_x_q == LAST_X) begin
                state_d  = IDLE;
                pix_x_d  = '0;
                line_adv = 1'b1;
              end else begin
                pix_x_d = pix_x_q + PIX_X_W'(1);
              end
            end
          end else if (!req_q) begin
            try_issue = 1'b1;
          end
        end
        DRAIN: begin
          if (start_of_line) restart_d = 1'b1;
          if (ack) begin
            req_d     = 1'b0;
            restart_d = 1'b0;
            state_d   = (restart_q || start_of_line) ? FETCH : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (line_adv) begin
`ifdef VRAM_LINE_FETCH_DOUBLE_SCAN_EN
      // Each VRAM line is shown twice; advance only on the second pass.
      parity_d = !parity_q;
      if (parity_q) line_y_d = line_y_q + LINE_Y_W'(1);
`else
      line_y_d = line_y_q + LINE_Y_W'(1);
`endif
    end

    if (try_issue && fifo_room) begin
      req_d  = 1'b1;
      addr_d = pixel_addr(line_y_d, pix_x_d, PITCH);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      line_y_q  <= '0;
      pix_x_q   <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      discard_q <= 1'b0;
      restart_q <= 1'b0;
`ifdef VRAM_LINE_FETCH_DOUBLE_SCAN_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      line_y_q  <= line_y_d;
      pix_x_q   <= pix_x_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
      restart_q <= restart_d;
`ifdef VRAM_LINE_FETCH_DOUBLE_SCAN_EN
      parity_q  <= parity_d;
`endif
    end
  end

  vram_line_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (mem_rd_data),
    .pop       (pix_ready),
    .pop_data  (pix_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign mem_rd_req = req_q;
  assign mem_addr   = addr_q;
  assign pix_valid  = !fifo_empty;
  assign fetch_busy = (state_q != IDLE);

endmodule
